dcp_tx_formatter: RTL and testbench

- Downstream of each debug command processor's transmit request port; converts one request into an ASCII byte stream for the UART transmitter.
- type_tx=0: emits din_tx[7:0] as a single raw character.
- type_tx=1: emits din_tx as 8 hex digits, MSB nibble first, optionally followed by a separator.
- Returns a one-cycle ack_tx once the last byte has been accepted by the UART.

---
 rtl/dcp_pkg.sv | 25 ++
 rtl/dcp_tx_formatter_if.sv | 21 ++
 rtl/hex_nibble_ascii.sv | 23 ++
 rtl/dcp_tx_formatter.sv | 145 ++++++++++++++
 tb/tb_dcp_tx_formatter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dcp_pkg.sv
// Shared types and constants for the debug command processor transmit path.
package dcp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic TX_TYPE_CHAR = 1'b0;
  localparam logic TX_TYPE_HEX  = 1'b1;

  function automatic logic [3:0] nibble_at(input logic [31:0] word, input logic [2:0] idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/dcp_tx_formatter_if.sv
// Request side and UART side of the transmit formatter, bundled as one interface.
interface dcp_tx_formatter_if;
  logic        req_tx;
  logic        type_tx;
  logic [31:0] din_tx;
  logic        ack_tx;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  modport master (
    output req_tx, type_tx, din_tx, tx_ready,
    input  ack_tx, tx_data, tx_valid, busy
  );

  modport slave (
    input  req_tx, type_tx, din_tx, tx_ready,
    output ack_tx, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/hex_nibble_ascii.sv
// Maps one 4-bit value to its ASCII hex digit; letter case chosen by HEX_UPPER.
module hex_nibble_ascii
  import dcp_pkg::*;
#(
  parameter bit HEX_UPPER = 1'b1
) (
  input  logic [3:0] i_nib,
  output logic [7:0] o_ascii
);

  // Digit lookup
  always_comb begin
    o_ascii = ASCII_0;
    if (i_nib < 4'd10) begin
      o_ascii = ASCII_0 + {4'h0, i_nib};
    end else if (HEX_UPPER) begin
      o_ascii = ASCII_UA + {4'h0, i_nib} - 8'd10;
    end else begin
      o_ascii = ASCII_LA + {4'h0, i_nib} - 8'd10;
    end
  end

endmodule

// File: rtl/dcp_tx_formatter.sv
// Turns one transmit request (raw char or 32-bit hex word) into a byte stream for the UART.
module dcp_tx_formatter
  import dcp_pkg::*;
#(
  parameter bit         HEX_UPPER  = 1'b1,
  parameter bit         HEX_SEP_EN = 1'b1,
  parameter logic [7:0] HEX_SEP    = ASCII_SP
) (
  input logic          clk,
  input logic          rst,
  dcp_tx_formatter_if.slave bus
);

  state_e      r_state, w_state_nx;
  logic [31:0] r_word, w_word_nx;
  logic        r_type, w_type_nx;
  logic [2:0]  r_nib, w_nib_nx;
  logic        r_sep_pend, w_sep_pend_nx;
  logic        r_last, w_last_nx;
  logic [7:0]  r_tx_data, w_tx_data_nx;
  logic        r_tx_valid, r_ack, r_busy;
  logic [2:0]  w_nib_dec;
  logic [3:0]  w_nib_sel;
  logic [7:0]  w_digit;
  logic        w_hs;

  assign w_hs      = r_tx_valid & bus.tx_ready;
  assign w_nib_dec = r_nib - 3'd1;

  // In IDLE the first digit comes straight from the payload; afterwards from the latched word
  always_comb begin
    w_nib_sel = 4'h0;
    if (r_state == IDLE) begin
      w_nib_sel = bus.din_tx[31:28];
    end else begin
      w_nib_sel = nibble_at(r_word, w_nib_dec);
    end
  end

  hex_nibble_ascii #(.HEX_UPPER(HEX_UPPER)) u_hex (
    .i_nib   (w_nib_sel),
    .o_ascii (w_digit)
  );

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_tx) w_state_nx = SEND;
        else            w_state_nx = IDLE;
      end
      SEND: begin
        if (w_hs && r_last) w_state_nx = ACK;
        else                w_state_nx = SEND;
      end
      ACK:      w_state_nx = WAIT_LOW;
      WAIT_LOW: begin
        if (!bus.req_tx) w_state_nx = IDLE;
        else             w_state_nx = WAIT_LOW;
      end
      default:  w_state_nx = IDLE;
    endcase
  end

  // Byte sequencing: r_last marks the byte whose handshake ends the transfer
  always_comb begin
    w_word_nx     = r_word;
    w_type_nx     = r_type;
    w_nib_nx      = r_nib;
    w_sep_pend_nx = r_sep_pend;
    w_last_nx     = r_last;
    w_tx_data_nx  = r_tx_data;
    case (r_state)
      IDLE: begin
        if (bus.req_tx) begin
          w_word_nx = bus.din_tx;
          w_type_nx = bus.type_tx;
          if (bus.type_tx == TX_TYPE_HEX) begin
            w_tx_data_nx  = w_digit;
            w_nib_nx      = 3'd7;
            w_sep_pend_nx = HEX_SEP_EN;
            w_last_nx     = 1'b0;
          end else begin
            w_tx_data_nx  = bus.din_tx[7:0];
            w_nib_nx      = 3'd0;
            w_sep_pend_nx = 1'b0;
            w_last_nx     = 1'b1;
          end
        end else begin
          w_word_nx = r_word;
        end
      end
      SEND: begin
        if (w_hs && !r_last && (r_type == TX_TYPE_HEX)) begin
          if (r_nib != 3'd0) begin
            w_tx_data_nx = w_digit;
            w_nib_nx     = w_nib_dec;
            w_last_nx    = (w_nib_dec == 3'd0) && !r_sep_pend;
          end else begin
            w_tx_data_nx  = HEX_SEP;
            w_sep_pend_nx = 1'b0;
            w_last_nx     = 1'b1;
          end
        end else begin
          w_tx_data_nx = r_tx_data;
        end
      end
      default: w_tx_data_nx = r_tx_data;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_word     <= 32'h0000_0000;
      r_type     <= TX_TYPE_CHAR;
      r_nib      <= 3'd0;
      r_sep_pend <= 1'b0;
      r_last     <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_word     <= w_word_nx;
      r_type     <= w_type_nx;
      r_nib      <= w_nib_nx;
      r_sep_pend <= w_sep_pend_nx;
      r_last     <= w_last_nx;
      r_tx_data  <= w_tx_data_nx;
      r_tx_valid <= (w_state_nx == SEND);
      r_ack      <= (w_state_nx == ACK);
      r_busy     <= (w_state_nx != IDLE);
    end
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.ack_tx   = r_ack;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_dcp_tx_formatter.sv
// Directed bench for dcp_tx_formatter: default instance plus a lowercase-hex instance.
module tb_dcp_tx_formatter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  bit   rand_ready;
  bit   scramble;

  dcp_tx_formatter_if if0 ();
  dcp_tx_formatter_if if1 ();

  dcp_tx_formatter u_dut (.clk(clk), .rst(rst), .bus(if0));
  dcp_tx_formatter #(.HEX_UPPER(1'b0)) u_dut_lc (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         ack0, ack1, vcnt0, stall_err0;
  logic       prev_stall0;
  logic [7:0] prev_data0;

  initial begin
    ack0 = 0; ack1 = 0; vcnt0 = 0; stall_err0 = 0;
    prev_stall0 = 1'b0; prev_data0 = 8'h00;
  end

  // Byte/ack monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (if0.tx_valid && if0.tx_ready) q0.push_back(if0.tx_data);
    if (if1.tx_valid && if1.tx_ready) q1.push_back(if1.tx_data);
    if (if0.ack_tx) ack0 <= ack0 + 1;
    if (if1.ack_tx) ack1 <= ack1 + 1;
    if (if0.tx_valid) vcnt0 <= vcnt0 + 1;
    if (prev_stall0 && (!if0.tx_valid || if0.tx_data !== prev_data0)) stall_err0 <= stall_err0 + 1;
    prev_stall0 <= if0.tx_valid && !if0.tx_ready;
    prev_data0  <= if0.tx_data;
  end

  logic [7:0] exp_hex [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h20};
  logic [7:0] exp_lc  [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64, 8'h20};
  logic [7:0] exp_dead[9] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h20};
  logic [7:0] exp_ff  [9] = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h20};
  logic [7:0] exp_zero[9] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h20};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request on if0, wait (bounded) for ack, hold, then drop req for 'low' cycles
  task automatic drive0(input logic typ, input logic [31:0] din, input int hold, input int low,
                        output int cyc, output bit got_ack);
    if0.req_tx  = 1'b1;
    if0.type_tx = typ;
    if0.din_tx  = din;
    cyc = 0;
    got_ack = 1'b0;
    while (!got_ack && cyc < 300) begin
      if (rand_ready) if0.tx_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (scramble) begin
        if0.din_tx  = $urandom;
        if0.type_tx = ~if0.type_tx;
      end
      if (if0.ack_tx === 1'b1) got_ack = 1'b1;
    end
    if0.tx_ready = 1'b1;
    repeat (hold) tick();
    if0.req_tx = 1'b0;
    repeat (low) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_checks++; if (if0.tx_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if0.tx_valid); else n_pass++;
    n_checks++; if (if0.ack_tx !== 1'b0) $display("FAIL reset_ack got %b want 0", if0.ack_tx); else n_pass++;
    n_checks++; if (if0.tx_data !== 8'h00) $display("FAIL reset_data got %h want 00", if0.tx_data); else n_pass++;
    n_checks++; if (if0.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", if0.busy); else n_pass++;
    n_checks++; if (if1.tx_valid !== 1'b0) $display("FAIL reset_valid_lc got %b want 0", if1.tx_valid); else n_pass++;
  endtask

  task automatic test_raw_char();
    int cyc; bit ok; int b; int a; int v;
    b = q0.size(); a = ack0; v = vcnt0;
    drive0(1'b0, 32'h0000_0044, 0, 2, cyc, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL raw_ack_timeout got %b want 1", ok); else n_pass++;
    n_checks++; if (cyc !== 2) $display("FAIL raw_ack_latency got %0d want 2", cyc); else n_pass++;
    n_checks++; if (q0.size() - b !== 1) $display("FAIL raw_count got %0d want 1", q0.size() - b); else n_pass++;
    n_checks++; if (q0.size() > b && q0[b] !== 8'h44) $display("FAIL raw_byte got %h want 44", q0[b]); else n_pass++;
    n_checks++; if (ack0 - a !== 1) $display("FAIL raw_acks got %0d want 1", ack0 - a); else n_pass++;
    n_checks++; if (vcnt0 - v !== 1) $display("FAIL raw_valid_cycles got %0d want 1", vcnt0 - v); else n_pass++;
    n_checks++; if (if0.busy !== 1'b0) $display("FAIL raw_busy_after got %b want 0", if0.busy); else n_pass++;
  endtask

  task automatic test_hex_word();
    int cyc; bit ok; int b; int a; logic [7:0] got;
    b = q0.size(); a = ack0;
    drive0(1'b1, 32'h1234_ABCD, 0, 2, cyc, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL hex_ack_timeout got %b want 1", ok); else n_pass++;
    n_checks++; if (cyc !== 10) $display("FAIL hex_ack_latency got %0d want 10", cyc); else n_pass++;
    n_checks++; if (q0.size() - b !== 9) $display("FAIL hex_count got %0d want 9", q0.size() - b); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      got = (b + i < q0.size()) ? q0[b + i] : 8'hxx;
      n_checks++; if (got !== exp_hex[i]) $display("FAIL hex_byte%0d got %h want %h", i, got, exp_hex[i]); else n_pass++;
    end
    n_checks++; if (ack0 - a !== 1) $display("FAIL hex_acks got %0d want 1", ack0 - a); else n_pass++;
  endtask

  task automatic test_hex_lower();
    int cyc; bit ok; int b; int a; logic [7:0] got;
    b = q1.size(); a = ack1; ok = 1'b0; cyc = 0;
    if1.tx_ready = 1'b1; if1.req_tx = 1'b1; if1.type_tx = 1'b1; if1.din_tx = 32'h1234_ABCD;
    while (!ok && cyc < 50) begin
      tick();
      cyc++;
      if (if1.ack_tx === 1'b1) ok = 1'b1;
    end
    if1.req_tx = 1'b0;
    repeat (2) tick();
    n_checks++; if (ok !== 1'b1) $display("FAIL lc_ack_timeout got %b want 1", ok); else n_pass++;
    n_checks++; if (q1.size() - b !== 9) $display("FAIL lc_count got %0d want 9", q1.size() - b); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      got = (b + i < q1.size()) ? q1[b + i] : 8'hxx;
      n_checks++; if (got !== exp_lc[i]) $display("FAIL lc_byte%0d got %h want %h", i, got, exp_lc[i]); else n_pass++;
    end
    n_checks++; if (ack1 - a !== 1) $display("FAIL lc_acks got %0d want 1", ack1 - a); else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc; bit ok; int b; int a; int s; logic [7:0] got;
    b = q0.size(); a = ack0; s = stall_err0;
    rand_ready = 1'b1;
    drive0(1'b1, 32'hDEAD_BEEF, 0, 2, cyc, ok);
    rand_ready = 1'b0;
    n_checks++; if (ok !== 1'b1) $display("FAIL bp_ack_timeout got %b want 1", ok); else n_pass++;
    n_checks++; if (q0.size() - b !== 9) $display("FAIL bp_count got %0d want 9", q0.size() - b); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      got = (b + i < q0.size()) ? q0[b + i] : 8'hxx;
      n_checks++; if (got !== exp_dead[i]) $display("FAIL bp_byte%0d got %h want %h", i, got, exp_dead[i]); else n_pass++;
    end
    n_checks++; if (ack0 - a !== 1) $display("FAIL bp_acks got %0d want 1", ack0 - a); else n_pass++;
    n_checks++; if (stall_err0 - s !== 0) $display("FAIL bp_stall_changes got %0d want 0", stall_err0 - s); else n_pass++;
  endtask

  task automatic test_held_request();
    int cyc; bit ok; int b; int a; int v;
    b = q0.size(); a = ack0;
    if0.req_tx = 1'b1; if0.type_tx = 1'b0; if0.din_tx = 32'h0000_0055;
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < 50) begin
      tick();
      cyc++;
      if (if0.ack_tx === 1'b1) ok = 1'b1;
    end
    v = vcnt0;
    repeat (5) tick();
    n_checks++; if (ok !== 1'b1) $display("FAIL held_ack_timeout got %b want 1", ok); else n_pass++;
    n_checks++; if (vcnt0 - v !== 0) $display("FAIL held_no_restart got %0d want 0", vcnt0 - v); else n_pass++;
    n_checks++; if (if0.busy !== 1'b1) $display("FAIL held_busy got %b want 1", if0.busy); else n_pass++;
    n_checks++; if (ack0 - a !== 1) $display("FAIL held_acks got %0d want 1", ack0 - a); else n_pass++;
    if0.req_tx = 1'b0;
    tick();
    b = q0.size(); a = ack0;
    drive0(1'b0, 32'h0000_003A, 0, 2, cyc, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rearm_ack_timeout got %b want 1", ok); else n_pass++;
    n_checks++; if (q0.size() - b !== 1) $display("FAIL rearm_count got %0d want 1", q0.size() - b); else n_pass++;
    n_checks++; if (q0.size() > b && q0[b] !== 8'h3A) $display("FAIL rearm_byte got %h want 3a", q0[b]); else n_pass++;
    n_checks++; if (ack0 - a !== 1) $display("FAIL rearm_acks got %0d want 1", ack0 - a); else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    int cyc; bit ok; int b; int a; logic [7:0] got;
    logic [7:0] exp3 [3] = '{8'h43, 8'h41, 8'h46};
    b = q0.size(); a = ack0;
    if0.tx_ready = 1'b1; if0.req_tx = 1'b1; if0.type_tx = 1'b1; if0.din_tx = 32'hCAFE_F00D;
    repeat (4) tick();
    rst = 1'b1; if0.req_tx = 1'b0;
    tick();
    n_checks++; if (if0.tx_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", if0.tx_valid); else n_pass++;
    n_checks++; if (if0.ack_tx !== 1'b0) $display("FAIL mid_rst_ack got %b want 0", if0.ack_tx); else n_pass++;
    n_checks++; if (if0.busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", if0.busy); else n_pass++;
    n_checks++; if (if0.tx_data !== 8'h00) $display("FAIL mid_rst_data got %h want 00", if0.tx_data); else n_pass++;
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (ack0 - a !== 0) $display("FAIL mid_rst_no_ack got %0d want 0", ack0 - a); else n_pass++;
    n_checks++; if (q0.size() - b !== 4) $display("FAIL mid_rst_count got %0d want 4", q0.size() - b); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      got = (b + i < q0.size()) ? q0[b + i] : 8'hxx;
      n_checks++; if (got !== exp3[i]) $display("FAIL mid_rst_byte%0d got %h want %h", i, got, exp3[i]); else n_pass++;
    end
    b = q0.size(); a = ack0;
    drive0(1'b1, 32'hFFFF_FFFF, 0, 2, cyc, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL ff_ack_timeout got %b want 1", ok); else n_pass++;
    n_checks++; if (q0.size() - b !== 9) $display("FAIL ff_count got %0d want 9", q0.size() - b); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      got = (b + i < q0.size()) ? q0[b + i] : 8'hxx;
      n_checks++; if (got !== exp_ff[i]) $display("FAIL ff_byte%0d got %h want %h", i, got, exp_ff[i]); else n_pass++;
    end
  endtask

  task automatic test_payload_stability();
    int cyc; bit ok; int b; int a; logic [7:0] got;
    b = q0.size(); a = ack0;
    scramble = 1'b1;
    drive0(1'b1, 32'h0000_0000, 0, 2, cyc, ok);
    scramble = 1'b0;
    n_checks++; if (ok !== 1'b1) $display("FAIL stab_ack_timeout got %b want 1", ok); else n_pass++;
    n_checks++; if (q0.size() - b !== 9) $display("FAIL stab_count got %0d want 9", q0.size() - b); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      got = (b + i < q0.size()) ? q0[b + i] : 8'hxx;
      n_checks++; if (got !== exp_zero[i]) $display("FAIL stab_byte%0d got %h want %h", i, got, exp_zero[i]); else n_pass++;
    end
    n_checks++; if (ack0 - a !== 1) $display("FAIL stab_acks got %0d want 1", ack0 - a); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rand_ready = 1'b0; scramble = 1'b0;
    rst = 1'b1;
    if0.req_tx = 1'b0; if0.type_tx = 1'b0; if0.din_tx = 32'h0; if0.tx_ready = 1'b1;
    if1.req_tx = 1'b0; if1.type_tx = 1'b0; if1.din_tx = 32'h0; if1.tx_ready = 1'b1;
    test_reset();
    test_raw_char();
    test_hex_word();
    test_hex_lower();
    test_backpressure();
    test_held_request();
    test_reset_mid_word();
    test_payload_stability();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
